// File: rtl/wb_initiator.sv
// Classic Wishbone initiator: one valid/ready command becomes one bus cycle,
// with a bounded wait for ack, and the outcome is returned on a valid/ready response port.
module wb_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  // command port
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_adr_i,
  input  logic [DATA_W-1:0]   cmd_dat_i,
  input  logic [DATA_W/8-1:0] cmd_sel_i,
  // response port
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_timeout_o,
  // Wishbone master
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i,
  // status
  output logic [7:0]          timeout_cnt_o
);

  localparam int SEL_W = DATA_W / 8;
  // Last wait-counter value before the cycle is abandoned; TIMEOUT <= 65535 fits in 16 bits.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [15:0]         wait_q, wait_d;
  logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                rsp_to_q, rsp_to_d;
  logic [7:0]          tcnt_q, tcnt_d;

  // NOTE: every register is written with <= so all of them update from the same pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      wait_q    <= '0;
      rsp_dat_q <= '0;
      rsp_to_q  <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      wait_q    <= wait_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_to_q  <= rsp_to_d;
      tcnt_q    <= tcnt_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case below can infer a latch.
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    wait_d    = wait_q;
    rsp_dat_d = rsp_dat_q;
    rsp_to_d  = rsp_to_q;
    tcnt_d    = tcnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          wait_d  = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack is tested before expiry so a late-but-valid ack still completes normally.
        if (wbm_ack_i) begin
          cyc_d     = 1'b0;
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_to_d  = 1'b0;
          state_d   = RESP;
        end else if (wait_q == WAIT_LAST) begin
          cyc_d     = 1'b0;
          rsp_dat_d = '0;
          rsp_to_d  = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d   = RESP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_timeout_o = rsp_to_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: directed and randomized transactions checked
// against a transaction-level model of strobe length, response contents and timeout count.
module tb_wb_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic [SW-1:0] cmd_sel_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_timeout_o;
  logic [DW-1:0] rsp_dat_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [SW-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o, wbm_dat_i;
  logic [7:0]    timeout_cnt_o;

  int checks   = 0;
  int failures = 0;
  int model_tcnt = 0;

  always #5 clk = ~clk;

  wb_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_adr_i     (cmd_adr_i),
    .cmd_dat_i     (cmd_dat_i),
    .cmd_sel_i     (cmd_sel_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_dat_o     (rsp_dat_o),
    .rsp_timeout_o (rsp_timeout_o),
    .wbm_cyc_o     (wbm_cyc_o),
    .wbm_stb_o     (wbm_stb_o),
    .wbm_we_o      (wbm_we_o),
    .wbm_sel_o     (wbm_sel_o),
    .wbm_adr_o     (wbm_adr_o),
    .wbm_dat_o     (wbm_dat_o),
    .wbm_dat_i     (wbm_dat_i),
    .wbm_ack_i     (wbm_ack_i),
    .timeout_cnt_o (timeout_cnt_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // cyc and stb must never diverge while out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) check("cyc_eq_stb", 64'(wbm_cyc_o), 64'(wbm_stb_o));
  end

  // One complete transaction, entered and left on a negedge with the DUT idle.
  // lat = number of stb cycles before the slave acks (ack in stb cycle lat); <0 = never.
  task automatic run_cmd(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, input logic [DW-1:0] rdata, input int lat,
                         input int hold, input bit spur,
                         output int n_obs, output logic [DW-1:0] dat_obs, output logic to_obs);
    bit            exp_to;
    int            n_exp;
    logic [DW-1:0] exp_dat;
    exp_to  = !(lat >= 0 && lat < TO);
    n_exp   = exp_to ? TO : lat + 1;
    exp_dat = (we || exp_to) ? '0 : rdata;
    if (exp_to && model_tcnt < 255) model_tcnt++;

    check("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_we_i    = ~we;
    cmd_adr_i   = $urandom;
    cmd_dat_i   = $urandom;
    cmd_sel_i   = SW'($urandom);

    n_obs = 0;
    while (wbm_stb_o === 1'b1 && n_obs < TO + 4) begin
      check("wbm_we", 64'(wbm_we_o), 64'(we));
      check("wbm_adr", 64'(wbm_adr_o), 64'(adr));
      check("wbm_dat", 64'(wbm_dat_o), 64'(dat));
      check("wbm_sel", 64'(wbm_sel_o), 64'(sel));
      check("cmd_ready_bus", 64'(cmd_ready_o), 64'd0);
      check("rsp_valid_bus", 64'(rsp_valid_o), 64'd0);
      wbm_ack_i = (n_obs == lat);
      wbm_dat_i = (n_obs == lat) ? rdata : DW'($urandom);
      n_obs++;
      @(negedge clk);
    end
    wbm_ack_i = 1'b0;
    check("stb_cycles", 64'(n_obs), 64'(n_exp));

    dat_obs = rsp_dat_o;
    to_obs  = rsp_timeout_o;
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", 64'(rsp_valid_o), 64'd1);
      check("rsp_dat", 64'(rsp_dat_o), 64'(exp_dat));
      check("rsp_timeout", 64'(rsp_timeout_o), 64'(exp_to));
      check("timeout_cnt", 64'(timeout_cnt_o), 64'(model_tcnt));
      check("cmd_ready_resp", 64'(cmd_ready_o), 64'd0);
      check("cyc_resp", 64'(wbm_cyc_o), 64'd0);
      wbm_ack_i   = spur && (h == 0);
      wbm_dat_i   = $urandom;
      rsp_ready_i = (h == hold);
      @(negedge clk);
    end
    wbm_ack_i   = 1'b0;
    rsp_ready_i = 1'b0;
    check("rsp_valid_done", 64'(rsp_valid_o), 64'd0);
    check("cmd_ready_done", 64'(cmd_ready_o), 64'd1);
    check("timeout_cnt_done", 64'(timeout_cnt_o), 64'(model_tcnt));
  endtask

  initial begin
    int            n;
    logic [DW-1:0] d;
    logic          t;

    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    cmd_sel_i   = '0;
    rsp_ready_i = 1'b0;
    wbm_ack_i   = 1'b0;
    wbm_dat_i   = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    check("rst_stb", 64'(wbm_stb_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_dat", 64'(rsp_dat_o), 64'd0);
    check("rst_tcnt", 64'(timeout_cnt_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write, ack two cycles after stb rises: three strobe cycles.
    run_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 32'h5555_AAAA, 2, 0, 1'b0, n, d, t);
    check("wr_cycles", 64'(n), 64'd3);
    check("wr_rsp_dat", 64'(d), 64'd0);
    check("wr_rsp_to", 64'(t), 64'd0);

    // Read acked in the first strobe cycle.
    run_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'h1234_5678, 0, 0, 1'b0, n, d, t);
    check("rd_cycles", 64'(n), 64'd1);
    check("rd_rsp_dat", 64'(d), 64'h1234_5678);
    check("rd_tcnt", 64'(timeout_cnt_o), 64'd0);

    // No ack: strobe held TIMEOUT cycles then timeout response.
    run_cmd(1'b0, 32'h3000_0008, 32'h0, 4'h3, 32'hCAFE_F00D, -1, 0, 1'b0, n, d, t);
    check("to_cycles", 64'(n), 64'd4);
    check("to_rsp_to", 64'(t), 64'd1);
    check("to_rsp_dat", 64'(d), 64'd0);
    check("to_tcnt", 64'(timeout_cnt_o), 64'd1);

    // Ack in the last allowed cycle wins over expiry.
    run_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF, 32'h0BAD_CAFE, 3, 0, 1'b0, n, d, t);
    check("edge_cycles", 64'(n), 64'd4);
    check("edge_rsp_to", 64'(t), 64'd0);
    check("edge_rsp_dat", 64'(d), 64'h0BAD_CAFE);
    check("edge_tcnt", 64'(timeout_cnt_o), 64'd1);

    // Backpressure with a spurious ack while the response is held.
    run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'hA5A5_5A5A, 1, 5, 1'b1, n, d, t);
    check("bp_rsp_dat", 64'(d), 64'hA5A5_5A5A);

    for (int i = 0; i < 80; i++) begin
      int lat;
      lat = int'($urandom_range(0, TO + 1)) - 1;
      run_cmd(1'($urandom), $urandom, $urandom, SW'($urandom), $urandom, lat,
              int'($urandom_range(0, 3)), 1'($urandom), n, d, t);
    end

    // Asynchronous reset in the middle of a strobe.
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 32'h3000_0020;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("amid_cyc", 64'(wbm_cyc_o), 64'd0);
    check("amid_stb", 64'(wbm_stb_o), 64'd0);
    check("amid_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("amid_tcnt", 64'(timeout_cnt_o), 64'd0);
    check("amid_cmd_ready", 64'(cmd_ready_o), 64'd1);
    model_tcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF, 32'h7777_1111, 1, 0, 1'b0, n, d, t);
    check("post_rst_dat", 64'(d), 64'h7777_1111);

    // Saturating timeout counter.
    for (int i = 0; i < 300; i++)
      run_cmd(1'($urandom), $urandom, $urandom, SW'($urandom), $urandom, -1, 0, 1'b0, n, d, t);
    check("sat_tcnt", 64'(timeout_cnt_o), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Classic (non-pipelined) Wishbone bus initiator, the master end of the wishbone slave port our wrapped projects expose.
- Converts single commands from a valid/ready command port into one Wishbone cycle each, then returns the result on a valid/ready response port.
- Used to exercise wrapped projects from on-chip logic (e.g. an LA-driven sequencer) and as the synthesizable bus driver in block-level benches.
- Includes an ack timeout so a non-responding (inactive/tristated) project cannot hang the initiator.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, maximum cycles stb is held waiting for ack; range 1..65535.

Ports:
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid and ready are both high.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_W  address.
- cmd_dat_i  in  DATA_W  write data.
- cmd_sel_i  in  DATA_W/8  byte select.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when valid and ready are both high.
- rsp_dat_o  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_timeout_o  out  1  cycle ended by timeout, not ack.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  DATA_W/8  Wishbone byte select.
- wbm_adr_o  out  ADDR_W  Wishbone address.
- wbm_dat_o  out  DATA_W  Wishbone write data.
- wbm_dat_i  in  DATA_W  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- timeout_cnt_o  out  8  saturating count of timed-out cycles since reset.

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0 except cmd_ready_o = 1.
- All Wishbone outputs are registered. wbm_cyc_o == wbm_stb_o at all times.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On accept, latch we/adr/dat/sel into the wbm_* registers, set cyc = stb = 1, clear the wait counter, go to BUS.
  - Cycle timing: accept at edge N, cyc/stb high from edge N.
- BUS:
  - cmd_ready_o = 0; the counter increments each cycle.
  - Ack sampled high: capture wbm_dat_i into rsp_dat_o for reads (0 for writes), set rsp_timeout_o = 0, drop cyc/stb, set rsp_valid_o, go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: drop cyc/stb, set rsp_dat_o = 0, rsp_timeout_o = 1, set rsp_valid_o, increment timeout_cnt_o (saturates at 255), go to RESP.
  - Ack on the same edge as timeout expiry: ack wins, no timeout recorded.
  - wbm_adr/dat/sel/we are held stable for the whole cycle.
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_timeout_o are held until the handshake.
  - On rsp_ready_i, clear rsp_valid_o and go to IDLE.
  - The next command can be accepted on the edge after that.
  - Minimum issue interval is 3 cycles (IDLE, BUS, RESP).
- Latency: ack sampled at edge K gives rsp_valid_o high after edge K; cyc/stb drop after edge K, so each ack completes exactly one cycle.
- wbm_ack_i seen in IDLE or RESP (spurious or late) is ignored and changes no state.
- wbm_dat_o and wbm_adr_o keep their last values when cyc is low; this is don't-care for slaves.
- Reset asserted mid-cycle: cyc/stb drop immediately (asynchronously), any pending response is discarded, timeout_cnt_o clears.
- A wait-counter width of 16 bits is sufficient; no arithmetic overflow is possible within the TIMEOUT range.

Test Plan:
- Write: cmd we=1, adr=0x3000_0004, dat=0xDEADBEEF, sel=0xF; slave acks 2 cycles after stb -> wbm_* show those values for exactly 3 cycles, then rsp_valid with rsp_dat=0, rsp_timeout=0.
- Read: adr=0x3000_0000; slave drives 0x1234_5678 with ack on the first stb cycle -> cyc high for 1 cycle, rsp_dat=0x1234_5678, timeout_cnt_o stays 0.
- Timeout (TIMEOUT=4): no ack -> stb high for exactly 4 cycles, then rsp_timeout=1, rsp_dat=0, timeout_cnt_o=1. Ack raised on the 4th cycle -> normal completion, timeout_cnt_o unchanged.
- Backpressure: rsp_ready low for 5 cycles after a read -> rsp_valid and rsp_dat held constant, cmd_ready=0 throughout; a spurious ack pulse in RESP causes no change.
- Reset mid-cycle: assert wb_rst_ni low while stb=1 -> cyc/stb/rsp_valid go 0 without waiting for a clock edge; after release, cmd_ready=1 and the next command completes normally.
- Saturation: 300 consecutive timeouts -> timeout_cnt_o=255 and stays there.
